// File: rtl/input_event_hub.sv
// input_event_hub: merges NCH strobe-only sources into one ordered event stream.
// Each source owns a one-entry pending register. A round-robin arbiter moves one
// pending event per cycle into a first-word-fall-through FIFO. Each FIFO entry is
// tagged with its source channel. A strobe that lands on an undrained pending
// entry overwrites it and sets a sticky drop flag for that channel.
// Optional build macro: INPUT_HUB_DEDUP_EN. When it is defined, a strobe whose
// payload repeats that channel's last loaded payload is ignored (held-key repeats).
module input_event_hub #(
    parameter int NCH   = 4,
    parameter int DW    = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NCH-1:0]             ch_stb,
    input  logic [NCH*DW-1:0]          ch_data,
    input  logic                       ev_ready,
    output logic                       ev_valid,
    output logic [DW-1:0]              ev_data,
    output logic [$clog2(NCH)-1:0]     ev_chan,
    output logic [$clog2(DEPTH):0]     fill,
    output logic [NCH-1:0]             drop_flag,
    input  logic                       drop_clr
);

    localparam int CW = $clog2(NCH);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FILL_FULL = (AW+1)'(DEPTH);

    // Per-channel pending entries
    logic [NCH-1:0]  r_pend;
    logic [DW-1:0]   r_pend_data [NCH];
    logic [NCH-1:0]  r_drop;
    logic [CW-1:0]   r_rr;

    // FIFO storage and bookkeeping
    logic [CW+DW-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_fill;

    logic             w_found;
    logic [CW-1:0]    w_gnt_idx;
    logic             w_pop;
    logic             w_push;
    logic             w_can_accept;
    logic [NCH-1:0]   w_load;
    logic [NCH-1:0]   w_gnt;
    logic [CW+DW-1:0] w_head;

`ifdef INPUT_HUB_DEDUP_EN
    logic [NCH-1:0]  r_seen;
    logic [DW-1:0]   r_last [NCH];
`endif

    // Rotating priority search: first pending channel at or above rr, wrapping mod NCH
    always_comb begin : arb
        int idx;
        w_found   = 1'b0;
        w_gnt_idx = '0;
        idx       = 0;
        for (int k = 0; k < NCH; k++) begin
            idx = (int'(r_rr) + k) % NCH;
            if (!w_found && r_pend[idx]) begin
                w_found   = 1'b1;
                w_gnt_idx = CW'(idx);
            end
        end
    end

    assign ev_valid     = (r_fill != '0);
    assign w_pop        = ev_valid & ev_ready;
    // A full FIFO still takes a push in the cycle its head leaves
    assign w_can_accept = (r_fill != FILL_FULL) | w_pop;
    assign w_push       = w_found & w_can_accept;

    // Head is read combinationally so data is presented together with ev_valid
    assign w_head    = r_mem[r_rd_ptr];
    assign ev_data   = ev_valid ? w_head[DW-1:0]  : '0;
    assign ev_chan   = ev_valid ? w_head[DW +: CW] : '0;
    assign fill      = r_fill;
    assign drop_flag = r_drop;

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_chan
`ifdef INPUT_HUB_DEDUP_EN
            assign w_load[gi] = ch_stb[gi] &
                                ~(r_seen[gi] & (ch_data[gi*DW +: DW] == r_last[gi]));
`else
            assign w_load[gi] = ch_stb[gi];
`endif
            assign w_gnt[gi] = w_push & (w_gnt_idx == CW'(gi));
        end
    endgenerate

    // Pending entries, sticky drop flags (a new drop beats drop_clr) and dedup history
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pend <= '0;
            r_drop <= '0;
            for (int i = 0; i < NCH; i++) begin
                r_pend_data[i] <= '0;
            end
`ifdef INPUT_HUB_DEDUP_EN
            r_seen <= '0;
            for (int i = 0; i < NCH; i++) begin
                r_last[i] <= '0;
            end
`endif
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (w_load[i]) begin
                    r_pend[i]      <= 1'b1;
                    r_pend_data[i] <= ch_data[i*DW +: DW];
                end else if (w_gnt[i]) begin
                    r_pend[i] <= 1'b0;
                end
                if (w_load[i] && r_pend[i] && !w_gnt[i]) begin
                    r_drop[i] <= 1'b1;
                end else if (drop_clr) begin
                    r_drop[i] <= 1'b0;
                end
`ifdef INPUT_HUB_DEDUP_EN
                if (w_load[i]) begin
                    r_seen[i] <= 1'b1;
                    r_last[i] <= ch_data[i*DW +: DW];
                end
`endif
            end
        end
    end

    // FIFO storage write; contents need no reset because fill gates visibility
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {w_gnt_idx, r_pend_data[w_gnt_idx]};
        end
    end

    // FIFO pointers, occupancy and the round-robin pointer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_fill   <= '0;
            r_rr     <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                r_rr     <= (w_gnt_idx == CW'(NCH-1)) ? '0 : w_gnt_idx + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_fill <= r_fill + 1'b1;
                2'b01:   r_fill <= r_fill - 1'b1;
                default: r_fill <= r_fill;
            endcase
        end
    end

endmodule

// File: tb/tb_input_event_hub.sv
// Bench for input_event_hub: table vectors, directed corner sequences and a
// randomized run. Every cycle is checked against a queue-based reference model.
module tb_input_event_hub;

    localparam int NCH = 4, DW = 8, DEPTH = 16, CW = 2, AW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                reset = 1'b1;
    logic [NCH-1:0]      ch_stb = '0;
    logic [NCH*DW-1:0]   ch_data = '0;
    logic                ev_ready = 1'b0;
    logic                drop_clr = 1'b0;
    logic                ev_valid;
    logic [DW-1:0]       ev_data;
    logic [CW-1:0]       ev_chan;
    logic [AW:0]         fill;
    logic [NCH-1:0]      drop_flag;

    input_event_hub #(.NCH(NCH), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .ch_stb(ch_stb), .ch_data(ch_data),
        .ev_ready(ev_ready), .ev_valid(ev_valid), .ev_data(ev_data),
        .ev_chan(ev_chan), .fill(fill), .drop_flag(drop_flag), .drop_clr(drop_clr)
    );

    int checks = 0;
    int failures = 0;
    int dut_pops = 0;
    int last_pop_data = -1;
    int last_pop_chan = -1;

    // Reference model state
    bit m_pend [NCH];
    int m_pdata[NCH];
    bit m_drop [NCH];
    bit m_seen [NCH];
    int m_last [NCH];
    int m_rr;
    int q_chan[$];
    int q_data[$];

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int drop_vec();
        int v;
        v = 0;
        for (int i = 0; i < NCH; i++) if (m_drop[i]) v |= (1 << i);
        return v;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NCH; i++) begin
            m_pend[i] = 0; m_pdata[i] = 0; m_drop[i] = 0; m_seen[i] = 0; m_last[i] = 0;
        end
        m_rr = 0;
        q_chan.delete();
        q_data.delete();
    endtask

    // One clock of the behavioural rules, evaluated on the pre-edge state
    task automatic model_step();
        bit pop, found, push;
        int g;
        pop = (q_data.size() != 0) && ev_ready;
        found = 0;
        g = 0;
        for (int k = 0; k < NCH; k++) begin
            int c;
            c = (m_rr + k) % NCH;
            if (!found && m_pend[c]) begin found = 1; g = c; end
        end
        push = found && ((q_data.size() < DEPTH) || pop);
        if (pop) begin
            void'(q_data.pop_front());
            void'(q_chan.pop_front());
        end
        if (push) begin
            q_data.push_back(m_pdata[g]);
            q_chan.push_back(g);
            m_rr = (g + 1) % NCH;
        end
        for (int i = 0; i < NCH; i++) begin
            int d;
            bit gr, ld;
            d  = int'(ch_data[i*DW +: DW]);
            gr = push && (g == i);
            ld = ch_stb[i];
`ifdef INPUT_HUB_DEDUP_EN
            if (ld && m_seen[i] && (m_last[i] == d)) ld = 0;
            if (ld) begin m_seen[i] = 1; m_last[i] = d; end
`endif
            if (ld && m_pend[i] && !gr) m_drop[i] = 1;
            else if (drop_clr) m_drop[i] = 0;
            if (ld) begin m_pend[i] = 1; m_pdata[i] = d; end
            else if (gr) m_pend[i] = 0;
        end
    endtask

    task automatic compare_model(string tag);
        chk({tag, " ev_valid"}, int'(ev_valid), int'(q_data.size() != 0));
        chk({tag, " fill"}, int'(fill), q_data.size());
        chk({tag, " drop_flag"}, int'(drop_flag), drop_vec());
        if (q_data.size() != 0) begin
            chk({tag, " ev_data"}, int'(ev_data), q_data[0]);
            chk({tag, " ev_chan"}, int'(ev_chan), q_chan[0]);
        end
    endtask

    task automatic drive(logic [NCH-1:0] s, logic [NCH*DW-1:0] d, logic r, logic c);
        ch_stb = s; ch_data = d; ev_ready = r; drop_clr = c;
    endtask

    task automatic cycle(string tag);
        if (ev_valid && ev_ready) begin
            dut_pops++;
            last_pop_data = int'(ev_data);
            last_pop_chan = int'(ev_chan);
            $display("event chan=%0d data=%02h t=%0t", ev_chan, ev_data, $time);
        end
        model_step();
        @(posedge clk);
        #1;
        compare_model(tag);
    endtask

    task automatic do_reset();
        ch_stb = '0; drop_clr = 1'b0; reset = 1'b1;
        #1;
        model_clear();
        chk("reset ev_valid", int'(ev_valid), 0);
        chk("reset fill", int'(fill), 0);
        chk("reset drop_flag", int'(drop_flag), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    typedef struct {
        bit          rst;
        logic [3:0]  stb;
        logic [31:0] data;
        logic        rdy;
        logic        clr;
        logic        ev;
        logic [7:0]  d;
        logic [1:0]  ch;
        logic [4:0]  f;
        logic [3:0]  drop;
    } vec_t;

    vec_t tbl[$];

    initial begin
        // reset, single ch1 strobe -> visible two edges later
        tbl.push_back('{1, 4'b0000, 32'h0,        0, 0, 0, 8'h00, 2'd0, 5'd0, 4'b0000});
        tbl.push_back('{0, 4'b0010, 32'h00001A00, 0, 0, 0, 8'h00, 2'd0, 5'd0, 4'b0000});
        tbl.push_back('{0, 4'b0000, 32'h0,        0, 0, 1, 8'h1A, 2'd1, 5'd1, 4'b0000});
        tbl.push_back('{0, 4'b0000, 32'h0,        1, 0, 0, 8'h00, 2'd0, 5'd0, 4'b0000});
        // all four at once drain in channel order, then rr wraps to ch0
        tbl.push_back('{1, 4'b0000, 32'h0,        0, 0, 0, 8'h00, 2'd0, 5'd0, 4'b0000});
        tbl.push_back('{0, 4'b1111, 32'h13121110, 1, 0, 0, 8'h00, 2'd0, 5'd0, 4'b0000});
        tbl.push_back('{0, 4'b0000, 32'h0,        1, 0, 1, 8'h10, 2'd0, 5'd1, 4'b0000});
        tbl.push_back('{0, 4'b0000, 32'h0,        1, 0, 1, 8'h11, 2'd1, 5'd1, 4'b0000});
        tbl.push_back('{0, 4'b0000, 32'h0,        1, 0, 1, 8'h12, 2'd2, 5'd1, 4'b0000});
        tbl.push_back('{0, 4'b0000, 32'h0,        1, 0, 1, 8'h13, 2'd3, 5'd1, 4'b0000});
        tbl.push_back('{0, 4'b1001, 32'h23000020, 1, 0, 0, 8'h00, 2'd0, 5'd0, 4'b0000});
        tbl.push_back('{0, 4'b0000, 32'h0,        1, 0, 1, 8'h20, 2'd0, 5'd1, 4'b0000});
        tbl.push_back('{0, 4'b0000, 32'h0,        1, 0, 1, 8'h23, 2'd3, 5'd1, 4'b0000});
        tbl.push_back('{0, 4'b0000, 32'h0,        1, 0, 0, 8'h00, 2'd0, 5'd0, 4'b0000});
        // strobe coinciding with grant: both payloads delivered, no drop
        tbl.push_back('{0, 4'b0001, 32'h00000030, 1, 0, 0, 8'h00, 2'd0, 5'd0, 4'b0000});
        tbl.push_back('{0, 4'b0001, 32'h00000031, 1, 0, 1, 8'h30, 2'd0, 5'd1, 4'b0000});
        tbl.push_back('{0, 4'b0000, 32'h0,        1, 0, 1, 8'h31, 2'd0, 5'd1, 4'b0000});
        tbl.push_back('{0, 4'b0000, 32'h0,        1, 0, 0, 8'h00, 2'd0, 5'd0, 4'b0000});
        // overwrite while another channel holds the grant -> drop, then clear
        tbl.push_back('{0, 4'b0100, 32'h00500000, 0, 0, 0, 8'h00, 2'd0, 5'd0, 4'b0000});
        tbl.push_back('{0, 4'b0100, 32'h00510000, 0, 0, 1, 8'h50, 2'd2, 5'd1, 4'b0000});
        tbl.push_back('{0, 4'b0011, 32'h00006160, 0, 0, 1, 8'h50, 2'd2, 5'd2, 4'b0000});
        tbl.push_back('{0, 4'b0010, 32'h00006200, 0, 0, 1, 8'h50, 2'd2, 5'd3, 4'b0010});
        tbl.push_back('{0, 4'b0000, 32'h0,        0, 1, 1, 8'h50, 2'd2, 5'd4, 4'b0000});
        tbl.push_back('{0, 4'b0000, 32'h0,        1, 0, 1, 8'h51, 2'd2, 5'd3, 4'b0000});
        tbl.push_back('{0, 4'b0000, 32'h0,        1, 0, 1, 8'h60, 2'd0, 5'd2, 4'b0000});
        tbl.push_back('{0, 4'b0000, 32'h0,        1, 0, 1, 8'h62, 2'd1, 5'd1, 4'b0000});
        tbl.push_back('{0, 4'b0000, 32'h0,        1, 0, 0, 8'h00, 2'd0, 5'd0, 4'b0000});

        model_clear();
        for (int n = 0; n < tbl.size(); n++) begin
            if (tbl[n].rst) begin
                do_reset();
            end else begin
                drive(tbl[n].stb, tbl[n].data, tbl[n].rdy, tbl[n].clr);
                cycle("model");
                chk($sformatf("tbl%0d ev_valid", n), int'(ev_valid), int'(tbl[n].ev));
                chk($sformatf("tbl%0d fill", n), int'(fill), int'(tbl[n].f));
                chk($sformatf("tbl%0d drop_flag", n), int'(drop_flag), int'(tbl[n].drop));
                if (tbl[n].ev) begin
                    chk($sformatf("tbl%0d ev_data", n), int'(ev_data), int'(tbl[n].d));
                    chk($sformatf("tbl%0d ev_chan", n), int'(ev_chan), int'(tbl[n].ch));
                end
            end
        end

        // Fill to 16 on ch2, 17th stays pending, 18th overwrites it
        do_reset();
        for (int k = 0; k < 17; k++) begin
            drive(4'b0100, 32'(8'h40 + k) << 16, 0, 0); cycle("fill");
            drive(4'b0000, 32'h0, 0, 0);               cycle("fill");
        end
        chk("full fill", int'(fill), 16);
        chk("full no drop", int'(drop_flag), 0);
        drive(4'b0100, 32'h00700000, 0, 0); cycle("overwrite");
        chk("overwrite drop2", int'(drop_flag), 4'b0100);
        // Full with ch0 pending and a pop: push and pop together
        drive(4'b0001, 32'h00000055, 0, 0); cycle("pend0");
        drive(4'b0000, 32'h0, 1, 0);        cycle("poppush");
        chk("poppush fill", int'(fill), 16);
        drive(4'b0100, 32'h00710000, 0, 1); cycle("setwins");
        chk("set beats clr", int'(drop_flag), 4'b0100);
        drive(4'b0000, 32'h0, 0, 1);        cycle("clr");
        chk("clr alone", int'(drop_flag), 0);
        dut_pops = 0;
        drive(4'b0000, 32'h0, 1, 0);
        for (int k = 0; k < 40; k++) cycle("drain");
        chk("drain count", dut_pops, 17);
        chk("drain last data", last_pop_data, 8'h71);
        chk("drain last chan", last_pop_chan, 2);
        chk("drain fill", int'(fill), 0);

        // Reset mid-stream with fill=5, pending entries and a drop flag
        do_reset();
        drive(4'b1111, 32'h04030201, 0, 0); cycle("mid");
        drive(4'b0010, 32'h00000900, 0, 0); cycle("mid");
        drive(4'b0000, 32'h0, 0, 0);
        for (int k = 0; k < 3; k++) cycle("mid");
        drive(4'b0001, 32'h00000005, 0, 0); cycle("mid");
        drive(4'b0110, 32'h00070600, 0, 0); cycle("mid");
        chk("mid fill", int'(fill), 5);
        chk("mid drop", int'(drop_flag), 4'b0010);
        do_reset();
        drive(4'b0000, 32'h0, 1, 0);
        for (int k = 0; k < 3; k++) cycle("postrst");
        chk("postrst valid", int'(ev_valid), 0);

        // Repeated keycodes on ch0
        do_reset();
        dut_pops = 0;
        for (int k = 0; k < 4; k++) begin
            drive(4'b0001, (k == 3) ? 32'h0 : 32'h0000001C, 1, 0); cycle("dedup");
            drive(4'b0000, 32'h0, 1, 0);
            for (int j = 0; j < 3; j++) cycle("dedup");
        end
`ifdef INPUT_HUB_DEDUP_EN
        chk("dedup count", dut_pops, 2);
`else
        chk("dedup count", dut_pops, 4);
`endif
        chk("dedup last", last_pop_data, 0);

        // Randomized traffic with phases of low and high consumer readiness
        do_reset();
        for (int k = 0; k < 800; k++) begin
            logic [NCH-1:0]    s;
            logic [NCH*DW-1:0] d;
            int rdy_pct;
            rdy_pct = ((k / 100) % 2 == 0) ? 80 : 15;
            for (int i = 0; i < NCH; i++) begin
                s[i] = ($urandom_range(0, 99) < 35);
                d[i*DW +: DW] = 8'($urandom_range(0, 3));
            end
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                drive(s, d, ($urandom_range(0, 99) < rdy_pct), ($urandom_range(0, 99) < 5));
                cycle("rand");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
